// File: rtl/cmp_scan_ctrl_pkg.sv
// Shared definitions for the cmp_scan_ctrl search controller:
// state encoding and default geometry.
package cmp_scan_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW    = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SCAN = ST_SCAN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/cmp_scan_ctrl_if.sv
// Host-side bus of cmp_scan_ctrl: table write port, search command and results.
//
// Handshake: there is no ready signal. A start pulse is accepted only while the
// controller is idle (busy=0 and done=0); otherwise it is dropped. Writes are
// likewise only accepted while idle. Results are valid in the done cycle and
// stay valid until the next accepted start.
interface cmp_scan_ctrl_if
  import cmp_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [WIDTH-1:0] key;
  logic             busy;
  logic             done;
  logic             found;
  logic [AW-1:0]    match_idx;
  logic [AW:0]      match_cnt;
  state_t           dbg_state;

  modport master (
    output wr_en, wr_addr, wr_data, start, key,
    input  busy, done, found, match_idx, match_cnt, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, key,
    output busy, done, found, match_idx, match_cnt, dbg_state
  );

endinterface

// File: rtl/cmp_scan_ctrl_key_match.sv
// WIDTH-bit equality comparator shared by every step of a table scan.
module cmp_scan_ctrl_key_match #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  assign eq = (a == b);

endmodule

// File: rtl/cmp_scan_ctrl.sv
// Table search controller: walks a DEPTH-entry table one entry per cycle through
// a single comparator and reports hit/miss, lowest matching index and match count.
module cmp_scan_ctrl
  import cmp_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input logic           clk,
  input logic           rst,
  cmp_scan_ctrl_if.slave bus
);

  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  state_t           state_q;
  logic [WIDTH-1:0] table_q [DEPTH];
  logic [WIDTH-1:0] key_q;
  logic [AW-1:0]    idx_q;
  logic             busy_q;
  logic             done_q;
  logic             found_q;
  logic [AW-1:0]    match_idx_q;
  logic [AW:0]      match_cnt_q;
  logic             hit;

  cmp_scan_ctrl_key_match #(
    .WIDTH(WIDTH)
  ) u_key_match (
    .a  (table_q[idx_q]),
    .b  (key_q),
    .eq (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      match_idx_q <= '0;
      match_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // A write in the start cycle lands before the first compare, so the
          // search observes it.
          if (bus.wr_en) begin
            table_q[bus.wr_addr] <= bus.wr_data;
          end
          if (bus.start) begin
            key_q       <= bus.key;
            idx_q       <= '0;
            found_q     <= 1'b0;
            match_idx_q <= '0;
            match_cnt_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (hit) begin
            match_cnt_q <= match_cnt_q + CNT_ONE;
            if (!found_q) begin
              found_q     <= 1'b1;
              match_idx_q <= idx_q;
            end
          end
          if (idx_q == IDX_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.match_idx = match_idx_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cmp_scan_ctrl.sv
// Self-checking bench for cmp_scan_ctrl: directed cases plus randomized searches
// compared against a simple table model.
module tb_cmp_scan_ctrl;
  import cmp_scan_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk;
  logic rst;

  cmp_scan_ctrl_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  cmp_scan_ctrl #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference table and scoreboard of {found, match_idx, match_cnt}
  logic [WIDTH-1:0]  tbl [DEPTH];
  logic [2*AW+1:0]   exp_q[$];

  task automatic check(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [2*AW+1:0] model_result(input logic [WIDTH-1:0] k);
    int cnt;
    int first;
    cnt   = 0;
    first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl[i] == k) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    if (first < 0) first = 0;
    return {(cnt > 0), AW'(first), (AW + 1)'(cnt)};
  endfunction

  task automatic write_entry(input int addr, input int data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = WIDTH'(data);
    tbl[addr]   = WIDTH'(data);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // One search; optionally a same-cycle write, optionally foreign traffic during SCAN.
  task automatic search(input int k, input bit with_wr, input int wa, input int wd,
                        input bit inject);
    logic [2*AW+1:0] e;
    int  cyc;
    bit  seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = WIDTH'(k);
    if (with_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(wa);
      bus.wr_data = WIDTH'(wd);
      tbl[wa]     = WIDTH'(wd);
    end
    exp_q.push_back(model_result(WIDTH'(k)));
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    seen = 1'b0;
    cyc  = 1;
    while (!seen && cyc <= DEPTH + 4) begin
      if (bus.done) begin
        seen = 1'b1;
        check("done_latency", cyc, DEPTH + 1);
        check("busy_in_done", int'(bus.busy), 0);
        e = exp_q.pop_front();
        check("found", int'(bus.found), int'(e[2*AW+1]));
        check("match_idx", int'(bus.match_idx), int'(e[2*AW:AW+1]));
        check("match_cnt", int'(bus.match_cnt), int'(e[AW:0]));
      end else begin
        if (cyc <= DEPTH) check("busy_scan", int'(bus.busy), 1);
        if (inject && cyc == 2) begin
          bus.start   = 1'b1;
          bus.key     = 8'd10;
          bus.wr_en   = 1'b1;
          bus.wr_addr = 3'd3;
          bus.wr_data = 8'd99;
        end else if (inject && cyc == 3) begin
          bus.start = 1'b0;
          bus.wr_en = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      void'(exp_q.pop_front());
    end else begin
      @(negedge clk);
      check("done_one_cycle", int'(bus.done), 0);
      check("idle_after_done", int'(bus.dbg_state), int'(ST_IDLE));
      check("hold_cnt", int'(bus.match_cnt), int'(e[AW:0]));
      check("hold_idx", int'(bus.match_idx), int'(e[2*AW:AW+1]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_found"}, int'(bus.found), 0);
    check({tag, "_idx"}, int'(bus.match_idx), 0);
    check({tag, "_cnt"}, int'(bus.match_cnt), 0);
    check({tag, "_state"}, int'(bus.dbg_state), int'(ST_IDLE));
  endtask

  task automatic reset_mid_scan();
    int dn;
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = 8'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    // now in the 4th SCAN cycle
    check("pre_rst_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("no_done_after_rst", dn, 0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.key     = '0;
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // all-zero table, key 0: every entry matches
    search(0, 1'b0, 0, 0, 1'b0);

    begin
      int vals [DEPTH] = '{10, 20, 30, 20, 50, 20, 70, 80};
      for (int i = 0; i < DEPTH; i++) write_entry(i, vals[i]);
    end
    search(20, 1'b0, 0, 0, 1'b0);
    search(99, 1'b0, 0, 0, 1'b0);

    // write and start during SCAN must both be dropped
    search(20, 1'b0, 0, 0, 1'b1);
    search(99, 1'b0, 0, 0, 1'b0);
    search(10, 1'b0, 0, 0, 1'b0);

    reset_mid_scan();
    search(0, 1'b0, 0, 0, 1'b0);

    begin
      int vals [DEPTH] = '{10, 20, 30, 20, 50, 20, 70, 80};
      for (int i = 0; i < DEPTH; i++) write_entry(i, vals[i]);
    end
    // same-cycle write is visible to the search it accompanies
    search(20, 1'b1, 7, 20, 1'b0);

    // randomized: small value range so hits and multi-hits are common
    for (int it = 0; it < 10; it++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) write_entry($urandom_range(0, DEPTH - 1), $urandom_range(0, 3));
      search($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
